// File: rtl/az_link_pkg.sv
// Shared definitions for the single-wire frame link: state encoding, slot levels, parity.
package az_link_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_GUARD  = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;
  localparam logic [2:0] ST_GAP    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_GUARD  = ST_GUARD,
    S_PARITY = ST_PARITY,
    S_DATA   = ST_DATA,
    S_STOP   = ST_STOP,
    S_GAP    = ST_GAP
  } link_state_e;

  localparam logic START_LVL   = 1'b1;
  localparam logic STOP_LVL    = 1'b1;
  localparam logic IDLE_LVL    = 1'b0;
  localparam int   GUARD_SLOTS = 1;
  localparam int   GAP_SLOTS   = 1;

  // Even parity over a word zero-extended to 32 bits (extension does not change parity).
  function automatic logic calc_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/tx.sv
// Serial frame transmitter: START, GUARD, PARITY, data LSB first, STOP, GAP.
// Optional build macro TX_PARITY_INJECT_EN adds corrupt_par to invert the parity slot.
module tx
  import az_link_pkg::*;
#(
  parameter int BIT_LEN = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BIT_LEN-1:0] data_in,
  input  logic               send,
  output logic               ready,
  output logic               channel_out,
  output logic               tx_done
`ifdef TX_PARITY_INJECT_EN
  , input logic              corrupt_par
`endif
);

  localparam int IDX_W = $clog2(BIT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BIT_LEN - 1);

  link_state_e        state_r;
  link_state_e        next_state_s;
  logic [BIT_LEN-1:0] shreg_r;
  logic [IDX_W-1:0]   bit_idx_r;
  logic               par_r;
  logic               accept_s;
  logic               line_s;
  logic               frame_par_s;

  assign accept_s = send & ready;

`ifdef TX_PARITY_INJECT_EN
  assign frame_par_s = calc_parity(32'(data_in)) ^ corrupt_par;
`else
  assign frame_par_s = calc_parity(32'(data_in));
`endif

  // Next-state and next line level; outputs are registered from the next state.
  always_comb begin
    next_state_s = state_r;
    line_s       = IDLE_LVL;
    case (state_r)
      S_IDLE:   next_state_s = accept_s ? S_START : S_IDLE;
      S_START:  next_state_s = S_GUARD;
      S_GUARD:  next_state_s = S_PARITY;
      S_PARITY: next_state_s = S_DATA;
      S_DATA:   next_state_s = (bit_idx_r == LAST_IDX) ? S_STOP : S_DATA;
      S_STOP:   next_state_s = S_GAP;
      S_GAP:    next_state_s = accept_s ? S_START : S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase
    case (next_state_s)
      S_START:  line_s = START_LVL;
      S_GUARD:  line_s = START_LVL;
      S_PARITY: line_s = par_r;
      S_DATA:   line_s = shreg_r[0];
      S_STOP:   line_s = STOP_LVL;
      default:  line_s = IDLE_LVL;
    endcase
  end

  // State, shift register, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      channel_out <= IDLE_LVL;
      ready       <= 1'b1;
      tx_done     <= 1'b0;
      shreg_r     <= '0;
      bit_idx_r   <= '0;
      par_r       <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      channel_out <= line_s;
      ready       <= (next_state_s == S_IDLE) || (next_state_s == S_GAP);
      tx_done     <= (next_state_s == S_STOP);
      // The word is consumed one bit per DATA slot, so shreg_r[0] is always the next bit.
      if (accept_s) begin
        shreg_r <= data_in;
        par_r   <= frame_par_s;
      end else if (next_state_s == S_DATA) begin
        shreg_r <= shreg_r >> 1;
      end else begin
        shreg_r <= shreg_r;
      end
      if ((state_r == S_DATA) && (next_state_s == S_DATA)) begin
        bit_idx_r <= bit_idx_r + IDX_W'(1);
      end else begin
        bit_idx_r <= '0;
      end
    end
  end

endmodule
